digit_to_uart_tx: RTL
=====================

// Module: digit_to_uart_tx
// PURPOSE
//  Transmit-side counterpart of the UART-LED receive path. Snapshots four 4-bit display digits
//  on a send request and hands them to the UART transmitter as two bytes, high byte first.
//  Sits between the digit source and the uart transmitter; a 16-bit word survives a
//  Tx -> Rx loopback unchanged.
// PARAMETERS
//  GAP_CYCLES   16     idle clk cycles inserted after each byte's Tx_BUSY falls (>=1)
//  ACK_TIMEOUT  1024   clk cycles to wait for Tx_BUSY to rise after Tx_WR before aborting
//  CNT_W        16     width of shared gap/timeout counter; must hold max(GAP_CYCLES,ACK_TIMEOUT)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reset      in   1  asynchronous, active-low (0 = in reset)
//  digit0     in   4  least-significant digit
//  digit1     in   4
//  digit2     in   4
//  digit3     in   4  most-significant digit
//  send       in   1  request; sampled only in IDLE
//  Tx_BUSY    in   1  transmitter busy, high while a byte is shifting out
//  Tx_DATA    out  8  byte presented to transmitter
//  Tx_WR      out  1  one-cycle write strobe, Tx_DATA valid in same cycle
//  Tx_EN      out  1  transmitter enable, high whenever not in IDLE
//  busy       out  1  high from accept until return to IDLE
//  done       out  1  one-cycle pulse on successful 2-byte completion
//  timeout    out  1  one-cycle pulse when ACK_TIMEOUT expires; transfer aborted
// BEHAVIOUR
//  Reset (async assert, sync-safe release): state=IDLE; Tx_DATA=8'h00; Tx_WR, Tx_EN, busy,
//   done, timeout = 0; snapshot = 16'hFFFF; counter = 0.
//  Snapshot: in IDLE with send=1 -> word <= {digit3,digit2,digit1,digit0}; later digit changes
//   are ignored until next accept.
//  Byte order: byte0 = word[15:8] = {digit3,digit2}; byte1 = word[7:0] = {digit1,digit0}.
//  FSM (registered outputs, one transition per clk):
//   IDLE      : send=1 and Tx_BUSY=0 -> LOAD (byte index=0), busy<=1. send while Tx_BUSY=1 is
//               held off (not lost while send stays high; a dropped pulse is not queued).
//   LOAD      : Tx_DATA<=current byte, Tx_WR<=1 for exactly 1 cycle -> WAIT_ACK, counter cleared.
//   WAIT_ACK  : Tx_BUSY=1 -> WAIT_DONE; else counter++; counter==ACK_TIMEOUT-1 -> timeout pulse,
//               IDLE, byte not retried.
//   WAIT_DONE : Tx_BUSY=0 -> GAP, counter cleared. No timeout here.
//   GAP       : count GAP_CYCLES; then index=0 -> index=1, LOAD; index=1 -> done pulse, IDLE.
//  Latency: send accepted at edge N -> first Tx_WR high in cycle N+1. done asserts
//   GAP_CYCLES cycles after second byte's Tx_BUSY fall.
//  Tx_DATA holds its value until next LOAD (not cleared on IDLE).
//  Simultaneous: send during non-IDLE ignored; done and timeout never both high.
//  Reset mid-transfer: immediate abort, no done/timeout pulse, remaining byte dropped.
//  Counter saturates; never wraps.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP),
//   BLANK_DIGIT = 4'hB, byte-order constants, shared with receive-side assembler.
//  One sub-module: tx_wait_counter (clear, enable, terminal-count compare against a port
//   value) used for both GAP and WAIT_ACK. FSM, snapshot, outputs in top.
// TESTING
//  Bench uses a transmitter model: Tx_BUSY rises 2 clk after Tx_WR, stays high 100 clk.
//  1. digits 3,2,1,0 = 1,2,3,4, pulse send -> Tx_DATA 8'h12 then 8'h34, two Tx_WR pulses,
//     one done pulse, busy low after.
//  2. Change digits to F,F,F,F one cycle after send accepted -> still sends 8'h12, 8'h34.
//  3. Model never raises Tx_BUSY, ACK_TIMEOUT=8 -> timeout pulse 8 cycles after Tx_WR,
//     no second Tx_WR, no done.
//  4. Assert reset during second byte's WAIT_DONE -> all outputs at reset values next
//     cycle; send after release transmits full pair again.
//  5. send held high with Tx_BUSY=1 in IDLE -> no Tx_WR until Tx_BUSY falls, then normal pair.
//  6. Loopback through uart receiver + digit assembler, word 16'hB0A5 -> receive-side digits
//     read B,0,A,5.

Source files
------------

// File: rtl/digit_to_uart_tx_pkg.sv
// Shared definitions for the digit <-> UART transmit/receive path: FSM states,
// blank-digit code and byte ordering of the 16-bit digit word.
`default_nettype none

package digit_to_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_e;

  localparam logic [3:0] BLANK_DIGIT = 4'hB;

  // Byte index 0 goes out first and carries the two most-significant digits.
  localparam logic BYTE_HI_IDX = 1'b0;
  localparam logic BYTE_LO_IDX = 1'b1;

  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic idx);
    return (idx == BYTE_HI_IDX) ? word[15:8] : word[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_to_uart_tx_wait_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count compare,
// shared between the inter-byte gap and the acknowledge timeout.
`default_nettype none

module tx_wait_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] terminal_i,
  output logic             at_terminal_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign at_terminal_o = (count_q == terminal_i);

endmodule

`default_nettype wire

// File: rtl/digit_to_uart_tx.sv
// Snapshots four display digits on request and sends them to a UART transmitter
// as two bytes, most-significant digit pair first.
`default_nettype none

module digit_to_uart_tx
  import digit_to_uart_tx_pkg::*;
#(
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       send,
  input  logic       Tx_BUSY,
  output logic [7:0] Tx_DATA,
  output logic       Tx_WR,
  output logic       Tx_EN,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_TC = CNT_W'(ACK_TIMEOUT - 1);

  tx_state_e   state_q, state_d;
  logic        idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tout_q, tout_d;
  logic        cnt_clr, cnt_en, cnt_tc;

  tx_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (cnt_clr),
    .enable_i     (cnt_en),
    .terminal_i   ((state_q == ST_GAP) ? GAP_TC : ACK_TC),
    .at_terminal_o(cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= BYTE_HI_IDX;
      word_q  <= 16'hFFFF;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A request arriving while the transmitter is still busy is held off.
        if (send && !Tx_BUSY) begin
          word_d  = {digit3, digit2, digit1, digit0};
          idx_d   = BYTE_HI_IDX;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = select_byte(word_q, idx_q);
        wr_d    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (Tx_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_tc) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!Tx_BUSY) begin
          cnt_clr = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_tc) begin
          if (idx_q == BYTE_HI_IDX) begin
            idx_d   = BYTE_LO_IDX;
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    en_d   = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  assign Tx_DATA = data_q;
  assign Tx_WR   = wr_q;
  assign Tx_EN   = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = tout_q;

endmodule

`default_nettype wire
